// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl
//  Description : Multi-cycle RV32M divide/remainder sequencer (DIV, DIVU,
//                REM, REMU). Restoring division, one quotient bit per cycle,
//                with sign correction, divide-by-zero and signed-overflow
//                behaviour as defined by the RISC-V M extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [1:0]        op_i,
    input  logic [WIDTH-1:0]  dividend_i,
    input  logic [WIDTH-1:0]  divisor_i,
    input  logic [ADDR_W-1:0] reg_waddr_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [WIDTH-1:0]  result_o,
    output logic [ADDR_W-1:0] reg_waddr_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   quo_q,    quo_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [WIDTH-1:0]   dvs_q,    dvs_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               is_rem_q, is_rem_d;
    logic               neg_q_q,  neg_q_d;
    logic               neg_r_q,  neg_r_d;
    logic [ADDR_W-1:0]  tag_q,    tag_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [ADDR_W-1:0]  waddr_q,  waddr_d;
    logic               valid_q,  valid_d;

    // Operand preparation: op_i[0]=1 selects the unsigned variants.
    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic               w_div_zero;

    assign w_dvd_neg  = ~op_i[0] & dividend_i[WIDTH-1];
    assign w_dvs_neg  = ~op_i[0] & divisor_i[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? (-dividend_i) : dividend_i;
    assign w_dvs_mag  = w_dvs_neg ? (-divisor_i)  : divisor_i;
    assign w_div_zero = (divisor_i == '0);

    // Restoring step: the partial remainder is always below the divisor, so
    // the top bit of the (WIDTH+1)-bit difference is a reliable borrow flag.
    logic [WIDTH:0]     w_rprime;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;

    assign w_rprime = {rem_q, quo_q[WIDTH-1]};
    assign w_diff   = w_rprime - {1'b0, dvs_q};
    assign w_qbit   = ~w_diff[WIDTH];

    // Next-state and datapath update; flush overrides everything at the end.
    always_comb begin
        state_d  = state_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        is_rem_d = is_rem_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        tag_d    = tag_q;
        result_d = result_q;
        waddr_d  = waddr_q;
        valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    is_rem_d = op_i[1];
                    tag_d    = reg_waddr_i;
                    cnt_d    = '0;
                    if (w_div_zero) begin
                        // Architectural result: quotient all ones, remainder
                        // is the raw dividend; skip the iteration entirely.
                        quo_d   = '1;
                        rem_d   = dividend_i;
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = S_FIX;
                    end else begin
                        quo_d   = w_dvd_mag;
                        rem_d   = '0;
                        dvs_d   = w_dvs_mag;
                        neg_q_d = w_dvd_neg ^ w_dvs_neg;
                        neg_r_d = w_dvd_neg;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = w_qbit ? w_diff[WIDTH-1:0] : w_rprime[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], w_qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST_CNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_rem_q) begin
                    result_d = neg_r_q ? (-rem_q) : rem_q;
                end else begin
                    result_d = neg_q_q ? (-quo_q) : quo_q;
                end
                waddr_d = tag_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            result_d = result_q;
            waddr_d  = waddr_q;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
            waddr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            is_rem_q <= is_rem_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            waddr_q  <= waddr_d;
            valid_q  <= valid_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign valid_o     = valid_q;
    assign result_o    = result_q;
    assign reg_waddr_o = waddr_q;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_ctrl
//  Description : Directed self-checking bench for div_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    localparam logic [1:0] C_DIV  = 2'b00;
    localparam logic [1:0] C_DIVU = 2'b01;
    localparam logic [1:0] C_REM  = 2'b10;
    localparam logic [1:0] C_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        flush_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  reg_waddr_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    int tests = 0;
    int fails = 0;

    div_ctrl #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .flush_i     (flush_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .reg_waddr_i (reg_waddr_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .reg_waddr_o (reg_waddr_o)
    );

    always #5 clk = ~clk;

    // Called 1 ns after a rising edge; issues the request on the next edge
    // (counted as edge 1) and returns 1 ns after the edge that raised valid_o.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          output logic [31:0] res, output logic [4:0] waddr,
                          output int lat, output bit got);
        op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = tag;
        start_i = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 start_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (valid_o === 1'b1) got = 1'b1;
        end
        res = result_o;
        waddr = reg_waddr_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00;
        dividend_i = '0; divisor_i = '0; reg_waddr_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        tests++; if (result_o !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 0", result_o); end
        tests++; if (reg_waddr_o !== 5'h0) begin fails++; $display("FAIL reset_waddr: got %h expected 0", reg_waddr_o); end
    endtask

    task automatic test_unsigned();
        logic [31:0] res; logic [4:0] wa; int lat; bit got;
        run_op(C_DIVU, 32'd100, 32'd7, 5'd17, res, wa, lat, got);
        tests++; if (!got || res !== 32'd14) begin fails++; $display("FAIL divu_100_7: got %h (valid %0b) expected %h", res, got, 32'd14); end
        tests++; if (lat !== 34) begin fails++; $display("FAIL divu_latency: got %0d expected 34", lat); end
        tests++; if (wa !== 5'd17) begin fails++; $display("FAIL divu_tag: got %0d expected 17", wa); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL busy_on_valid: got %b expected 0", busy_o); end
        // Back-to-back: issued in the valid cycle itself.
        run_op(C_REMU, 32'd100, 32'd7, 5'd18, res, wa, lat, got);
        tests++; if (!got || res !== 32'd2) begin fails++; $display("FAIL remu_100_7: got %h expected %h", res, 32'd2); end
        tests++; if (lat !== 34 || wa !== 5'd18) begin fails++; $display("FAIL back_to_back: lat %0d tag %0d expected 34 and 18", lat, wa); end
        @(posedge clk); #1;
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL valid_pulse: got %b expected 0", valid_o); end
    endtask

    task automatic test_signed();
        logic [31:0] res; logic [4:0] wa; int lat; bit got;
        run_op(C_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, res, wa, lat, got);
        tests++; if (!got || res !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_m7_2: got %h expected FFFFFFFD", res); end
        run_op(C_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, res, wa, lat, got);
        tests++; if (!got || res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rem_m7_2: got %h expected FFFFFFFF", res); end
        run_op(C_REM, 32'd7, 32'hFFFF_FFFE, 5'd3, res, wa, lat, got);
        tests++; if (!got || res !== 32'd1) begin fails++; $display("FAIL rem_7_m2: got %h expected 00000001", res); end
    endtask

    task automatic test_overflow();
        logic [31:0] res; logic [4:0] wa; int lat; bit got;
        run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, res, wa, lat, got);
        tests++; if (!got || res !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf: got %h expected 80000000", res); end
        run_op(C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, res, wa, lat, got);
        tests++; if (!got || res !== 32'h0) begin fails++; $display("FAIL rem_ovf: got %h expected 00000000", res); end
        run_op(C_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, res, wa, lat, got);
        tests++; if (!got || res !== 32'h0) begin fails++; $display("FAIL divu_big: got %h expected 00000000", res); end
    endtask

    task automatic test_div_zero();
        logic [31:0] res; logic [4:0] wa; int lat; bit got;
        run_op(C_DIV, 32'd5, 32'd0, 5'd8, res, wa, lat, got);
        tests++; if (!got || res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_zero: got %h expected FFFFFFFF", res); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL div_zero_latency: got %0d expected 2", lat); end
        run_op(C_REMU, 32'hDEAD_BEEF, 32'd0, 5'd9, res, wa, lat, got);
        tests++; if (!got || res !== 32'hDEAD_BEEF || lat !== 2) begin fails++; $display("FAIL remu_zero: got %h lat %0d expected DEADBEEF lat 2", res, lat); end
        tests++; if (wa !== 5'd9) begin fails++; $display("FAIL remu_zero_tag: got %0d expected 9", wa); end
    endtask

    task automatic test_ignore_start();
        int lat; bit got;
        op_i = C_DIVU; dividend_i = 32'd1000; divisor_i = 32'd10; reg_waddr_i = 5'd3;
        start_i = 1'b1;
        @(posedge clk); lat = 1;
        #1 start_i = 1'b0;
        repeat (9) begin @(posedge clk); lat++; #1; end
        op_i = C_REMU; dividend_i = 32'd55; divisor_i = 32'd5; reg_waddr_i = 5'd9;
        start_i = 1'b1;
        @(posedge clk); lat++;
        #1 start_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); lat++; #1;
            if (valid_o === 1'b1) got = 1'b1;
        end
        tests++; if (!got || result_o !== 32'd100 || reg_waddr_o !== 5'd3) begin fails++; $display("FAIL ignore_start: got %h tag %0d expected 00000064 tag 3", result_o, reg_waddr_o); end
        tests++; if (lat !== 34) begin fails++; $display("FAIL ignore_start_latency: got %0d expected 34", lat); end
    endtask

    task automatic test_flush();
        logic [31:0] res; logic [4:0] wa; int lat; bit got; bit seen;
        logic [31:0] prev_res; logic [4:0] prev_wa;
        prev_res = result_o; prev_wa = reg_waddr_o;
        op_i = C_DIVU; dividend_i = 32'd81; divisor_i = 32'd9; reg_waddr_i = 5'd4;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL flush_busy: got %b expected 0", busy_o); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen) begin fails++; $display("FAIL flush_no_valid: got activity 1 expected 0"); end
        tests++; if (result_o !== prev_res || reg_waddr_o !== prev_wa) begin fails++; $display("FAIL flush_hold: got %h/%0d expected %h/%0d", result_o, reg_waddr_o, prev_res, prev_wa); end
        // Flush and start together: the request is dropped.
        start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0; flush_i = 1'b0;
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL flush_wins: busy got %b expected 0", busy_o); end
        run_op(C_DIVU, 32'd81, 32'd9, 5'd4, res, wa, lat, got);
        tests++; if (!got || res !== 32'd9 || wa !== 5'd4) begin fails++; $display("FAIL after_flush: got %h tag %0d expected 00000009 tag 4", res, wa); end
    endtask

    task automatic test_async_reset();
        logic [31:0] res; logic [4:0] wa; int lat; bit got; bit seen;
        op_i = C_DIV; dividend_i = 32'd1000; divisor_i = 32'hFFFF_FFF6; reg_waddr_i = 5'd7;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #3 rst_n = 1'b0;
        #1;
        tests++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin fails++; $display("FAIL async_rst_ctrl: busy %b valid %b expected 0 0", busy_o, valid_o); end
        tests++; if (result_o !== 32'h0 || reg_waddr_o !== 5'h0) begin fails++; $display("FAIL async_rst_data: got %h/%0d expected 0/0", result_o, reg_waddr_o); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen) begin fails++; $display("FAIL post_reset_quiet: got activity 1 expected 0"); end
        run_op(C_DIV, 32'd1000, 32'hFFFF_FFF6, 5'd7, res, wa, lat, got);
        tests++; if (!got || res !== 32'hFFFF_FF9C || wa !== 5'd7) begin fails++; $display("FAIL post_reset_op: got %h tag %0d expected FFFFFF9C tag 7", res, wa); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_ignore_start();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle sequencer for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in the execute stage and stalls the pipeline while it iterates.
- Uses a restoring algorithm, one quotient bit per cycle, with an internal (WIDTH+1)-bit subtractor.
- Handles sign correction, divide-by-zero and signed overflow per the RISC-V M specification.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- ADDR_W, 5, width of the destination-register tag carried alongside the operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request; sampled only while busy_o=0.
- flush_i  input  1  pipeline flush; aborts any operation in flight.
- op_i  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0]).
- dividend_i  input  WIDTH  rs1 value, sampled with start_i.
- divisor_i  input  WIDTH  rs2 value, sampled with start_i.
- reg_waddr_i  input  ADDR_W  destination tag, sampled with start_i.
- busy_o  output  1  high whenever state != IDLE; drives the pipeline hold.
- valid_o  output  1  one-cycle pulse: result_o/reg_waddr_o are valid.
- result_o  output  WIDTH  quotient or remainder; holds its value until the next valid_o.
- reg_waddr_o  output  ADDR_W  tag of the completed operation.

Behaviour:
- Clocking/reset: single clock clk; reset rst_n is asynchronous, active-low.
- On rst_n=0: state=IDLE, busy_o=0, valid_o=0, result_o=0, reg_waddr_o=0, counter and datapath registers 0.
- FSM states: IDLE, CALC, FIX.
- Signed ops (DIV/REM): operands are converted to magnitudes at start.
  - neg_q = sign(dividend) XOR sign(divisor), with divisor != 0.
  - neg_r = sign(dividend).
- Unsigned ops: magnitudes = raw operands; neg_q=neg_r=0.
- IDLE, start_i=1, flush_i=0, divisor_i != 0 (edge E0):
  - latch magnitudes, op and tag; quotient register = dividend magnitude; remainder = 0; count = 0.
  - next state CALC.
- IDLE, start_i=1, divisor_i == 0 (edge E0):
  - no iteration; next state FIX with the forced result: quotient = all ones, remainder = dividend_i unmodified.
  - valid_o rises after E1 (latency 2 edges).
- CALC, each edge:
  - r' = {rem, quo[MSB]} (WIDTH+1 bits); diff = r' - {0, divisor}.
  - If diff >= 0: rem <= diff[WIDTH-1:0] and the shifted-in quotient bit = 1.
  - Else: rem <= r'[WIDTH-1:0] and the quotient bit = 0.
  - quo <= {quo[WIDTH-2:0], bit}; count increments.
  - After WIDTH edges (E1..E32), next state FIX.
- FIX (edge E33 for a normal op):
  - result_o = DIV/DIVU ? (neg_q ? -quo : quo) : (neg_r ? -rem : rem).
  - reg_waddr_o updated; valid_o=1 for exactly one cycle; next state IDLE.
- Latency: start sampled at E0, valid_o high in the cycle after E33 (34 edges); busy_o low in that same cycle, so back-to-back start is accepted on the valid cycle.
- Signed overflow: 0x80000000 / -1 is not special-cased; the magnitude path yields quotient 0x80000000 and remainder 0, which the spec requires.
- start_i while busy_o=1: ignored; latched operands unchanged.
- flush_i=1 in any state: next state IDLE, no valid_o, result_o/reg_waddr_o unchanged.
- flush_i and start_i in the same cycle: flush wins, the request is dropped.
- Reset asserted mid-operation: immediate return to reset values; no valid_o after release.
- All arithmetic wraps modulo 2^WIDTH; negation is two's complement.

Test Plan:
- DIVU 100/7 -> valid_o exactly 34 cycles after start, result_o=14; REMU same operands -> 2; reg_waddr_o equals the tag given at start.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; REM 7/0xFFFFFFFE(-2) -> 1.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU 0x80000000/0xFFFFFFFF -> 0.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF, REMU 0xDEADBEEF/0 -> 0xDEADBEEF, valid_o 2 cycles after start with no CALC cycles.
- Control:
  - start_i pulsed again at cycle 10 with different operands -> ignored, original result returned.
  - flush_i at cycle 20 -> busy_o low next cycle, no valid_o.
  - new start afterwards -> correct result.
- rst_n dropped asynchronously mid-CALC -> all outputs 0 without waiting for clk; after release busy_o=0 and no spurious valid_o.
